// File: rtl/scoreboard_hazard_unit.sv
// Issue-stage hazard unit: tracks the scalar EX/MEM stages and the vector pipe,
// and decides decode/scalar stalls, scalar operand forwarding and writeback arbitration.
module scoreboard_hazard_unit #(
  parameter int NUM_REGS  = 32,
  parameter int NUM_SRC   = 4,
  parameter int VEC_DEPTH = 9,
  localparam int RW = $clog2(NUM_REGS),
  localparam int CW = $clog2(VEC_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic                      issue_vec,
  input  logic                      issue_load,
  input  logic                      dst_valid,
  input  logic                      dst_file,
  input  logic [RW-1:0]             dst_reg,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_file,
  input  logic [NUM_SRC*RW-1:0]     src_reg,
  input  logic                      mem_stall_in,
  input  logic                      flush,
  output logic                      stall_decode,
  output logic                      stall_scalar,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      wb_vector_sel,
  output logic [CW-1:0]             vec_occupancy
);

  typedef struct packed {
    logic          valid;
    logic          load;
    logic          dv;
    logic          df;
    logic [RW-1:0] dr;
  } ex_ent_t;

  // MEM and vector entries never need the load flag: their results are final.
  typedef struct packed {
    logic          valid;
    logic          dv;
    logic          df;
    logic [RW-1:0] dr;
  } wr_ent_t;

  ex_ent_t       ex_q, ex_d;
  wr_ent_t       mem_q, mem_d;
  wr_ent_t       vec_q [VEC_DEPTH];
  wr_ent_t       vec_d [VEC_DEPTH];
  logic [CW-1:0] pend_q [2][NUM_REGS];
  logic [CW-1:0] pend_d [2][NUM_REGS];
  logic [CW-1:0] occ_q, occ_d;

  wr_ent_t             tail;
  logic                tail_wr, mem_wr, full, partial, accept;
  logic [2*NUM_SRC-1:0] fwd;
  logic [RW-1:0]       s_reg;
  logic                s_file, m_ex, m_mem;

  assign tail    = vec_q[VEC_DEPTH-1];
  assign tail_wr = tail.valid & tail.dv;
  assign mem_wr  = mem_q.valid & mem_q.dv;
  assign full    = mem_stall_in | (tail_wr & mem_wr & (tail.df == mem_q.df));

  always_comb begin
    partial = 1'b0;
    fwd     = '0;
    s_reg   = '0;
    s_file  = 1'b0;
    m_ex    = 1'b0;
    m_mem   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      s_reg  = src_reg[i*RW +: RW];
      s_file = src_file[i];
      m_ex   = src_valid[i] & ex_q.valid & ex_q.dv & (ex_q.df == s_file) & (ex_q.dr == s_reg);
      m_mem  = src_valid[i] & mem_wr & (mem_q.df == s_file) & (mem_q.dr == s_reg);
      if (src_valid[i] && (pend_q[s_file][s_reg] != '0)) partial = 1'b1;
      if (issue_vec) begin
        if (m_ex || m_mem) partial = 1'b1;
      end else if (m_ex && ex_q.load) begin
        partial = 1'b1;
      end else if (m_ex) begin
        fwd[2*i +: 2] = 2'b01;
      end else if (m_mem) begin
        fwd[2*i +: 2] = 2'b10;
      end
    end
    if (!issue_vec && dst_valid && (pend_q[dst_file][dst_reg] != '0)) partial = 1'b1;
    if (!issue_valid) begin
      partial = 1'b0;
      fwd     = '0;
    end
  end

  assign stall_decode  = partial | full;
  assign stall_scalar  = full;
  assign fwd_sel       = fwd;
  assign wb_vector_sel = tail_wr;
  assign vec_occupancy = occ_q;
  assign accept        = issue_valid & ~stall_decode & ~flush;

  // A flushed EX entry is killed outright: it neither stays in EX nor moves on to MEM.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (full) begin
      if (flush) ex_d.valid = 1'b0;
    end else begin
      mem_d = flush ? '0 : {ex_q.valid, ex_q.dv, ex_q.df, ex_q.dr};
      ex_d  = (accept && !issue_vec) ? {1'b1, issue_load, dst_valid, dst_file, dst_reg} : '0;
    end
  end

  always_comb begin
    vec_d[0] = (accept && issue_vec) ? {1'b1, dst_valid, dst_file, dst_reg} : '0;
    for (int unsigned i = 1; i < VEC_DEPTH; i++) vec_d[i] = vec_q[i-1];
    occ_d = '0;
    for (int unsigned i = 0; i < VEC_DEPTH; i++) occ_d = occ_d + CW'(vec_d[i].valid);
  end

  always_comb begin
    logic inc, dec;
    inc    = 1'b0;
    dec    = 1'b0;
    pend_d = pend_q;
    for (int unsigned f = 0; f < 2; f++) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        inc = accept & issue_vec & dst_valid & (dst_file == 1'(f)) & (dst_reg == RW'(r));
        dec = tail_wr & (tail.df == 1'(f)) & (tail.dr == RW'(r));
        if (inc && !dec && (pend_q[f][r] != CW'(VEC_DEPTH)))
          pend_d[f][r] = pend_q[f][r] + 1'b1;
        else if (dec && !inc && (pend_q[f][r] != '0))
          pend_d[f][r] = pend_q[f][r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      occ_q <= '0;
      for (int unsigned i = 0; i < VEC_DEPTH; i++) vec_q[i] <= '0;
      for (int unsigned f = 0; f < 2; f++)
        for (int unsigned r = 0; r < NUM_REGS; r++) pend_q[f][r] <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      occ_q <= occ_d;
      for (int unsigned i = 0; i < VEC_DEPTH; i++) vec_q[i] <= vec_d[i];
      for (int unsigned f = 0; f < 2; f++)
        for (int unsigned r = 0; r < NUM_REGS; r++) pend_q[f][r] <= pend_d[f][r];
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: directed vector table for the key hazard
// sequences, then random traffic against an in-flight-list reference model.
module tb_scoreboard_hazard_unit;
  localparam int NR = 32;
  localparam int NS = 4;
  localparam int VD = 9;
  localparam int RW = 5;
  localparam int CW = 4;

  logic clk;
  logic rst, issue_valid, issue_vec, issue_load, dst_valid, dst_file;
  logic [RW-1:0] dst_reg;
  logic [NS-1:0] src_valid, src_file;
  logic [NS*RW-1:0] src_reg;
  logic mem_stall_in, flush;
  logic stall_decode, stall_scalar, wb_vector_sel;
  logic [2*NS-1:0] fwd_sel;
  logic [CW-1:0] vec_occupancy;

  scoreboard_hazard_unit #(.NUM_REGS(NR), .NUM_SRC(NS), .VEC_DEPTH(VD)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_vec(issue_vec),
    .issue_load(issue_load), .dst_valid(dst_valid), .dst_file(dst_file), .dst_reg(dst_reg),
    .src_valid(src_valid), .src_file(src_file), .src_reg(src_reg),
    .mem_stall_in(mem_stall_in), .flush(flush), .stall_decode(stall_decode),
    .stall_scalar(stall_scalar), .fwd_sel(fwd_sel), .wb_vector_sel(wb_vector_sel),
    .vec_occupancy(vec_occupancy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_err;

  // current stimulus, shared by table and random phases
  bit r_rst, r_iv, r_vec, r_ld, r_dv, r_df, r_ms, r_fl;
  int r_dr;
  bit r_sv [NS];
  bit r_sf [NS];
  int r_sr [NS];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    rst = r_rst; issue_valid = r_iv; issue_vec = r_vec; issue_load = r_ld;
    dst_valid = r_dv; dst_file = r_df; dst_reg = r_dr[RW-1:0];
    mem_stall_in = r_ms; flush = r_fl;
    for (int i = 0; i < NS; i++) begin
      src_valid[i] = r_sv[i];
      src_file[i]  = r_sf[i];
      src_reg[i*RW +: RW] = r_sr[i][RW-1:0];
    end
  endtask

  typedef struct {
    bit rn, iv, vc, ld, dv, df; int dr;
    bit sv, sf; int sr; bit ms, fl;
    bit e_sd, e_ss; int e_fw; bit e_wb; int e_occ;
  } vec_t;

  function automatic vec_t R(bit rn, bit iv, bit vc, bit ld, bit dv, bit df, int dr,
                             bit sv, bit sf, int sr, bit ms, bit fl,
                             bit sd, bit ss, int fw, bit wb, int occ);
    vec_t v;
    v.rn = rn; v.iv = iv; v.vc = vc; v.ld = ld; v.dv = dv; v.df = df; v.dr = dr;
    v.sv = sv; v.sf = sf; v.sr = sr; v.ms = ms; v.fl = fl;
    v.e_sd = sd; v.e_ss = ss; v.e_fw = fw; v.e_wb = wb; v.e_occ = occ;
    return v;
  endfunction

  vec_t tbl[$];

  // ---------------- reference model ----------------
  typedef struct { bit w; bit f; int r; int age; } vent_t;
  typedef struct { bit valid; bit load; bit w; bit f; int r; } sop_t;
  vent_t vq[$];
  sop_t  m_ex, m_mem;

  function automatic int pending(bit f, int r);
    int n = 0;
    foreach (vq[k]) if (vq[k].w && vq[k].f == f && vq[k].r == r) n++;
    return n;
  endfunction

  function automatic bit hits(sop_t e, bit f, int r);
    return e.valid && e.w && e.f == f && e.r == r;
  endfunction

  task automatic model_expect(output bit sd, output bit ss, output bit wb, output int fw);
    bit part, tail_f;
    part = 0; wb = 0; tail_f = 0; fw = 0;
    foreach (vq[k]) if (vq[k].age == VD && vq[k].w) begin wb = 1; tail_f = vq[k].f; end
    ss = r_ms || (wb && m_mem.valid && m_mem.w && m_mem.f == tail_f);
    if (r_iv) begin
      for (int i = 0; i < NS; i++) begin
        bit e, m;
        if (!r_sv[i]) continue;
        e = hits(m_ex, r_sf[i], r_sr[i]);
        m = hits(m_mem, r_sf[i], r_sr[i]);
        if (pending(r_sf[i], r_sr[i]) > 0) part = 1;
        if (r_vec) begin
          if (e || m) part = 1;
        end else if (e && m_ex.load) part = 1;
        else if (e) fw += 1 << (2*i);
        else if (m) fw += 2 << (2*i);
      end
      if (!r_vec && r_dv && pending(r_df, r_dr) > 0) part = 1;
    end
    sd = part || ss;
  endtask

  task automatic model_edge(input bit sd, input bit ss);
    vent_t nq[$];
    bit acc;
    if (!r_rst) begin
      vq.delete();
      m_ex = '{default:0};
      m_mem = '{default:0};
      return;
    end
    acc = r_iv && !sd && !r_fl;
    foreach (vq[k]) if (vq[k].age < VD) nq.push_back('{vq[k].w, vq[k].f, vq[k].r, vq[k].age + 1});
    if (acc && r_vec) nq.push_back('{r_dv, r_df, r_dr, 1});
    vq = nq;
    if (ss) begin
      if (r_fl) m_ex.valid = 0;
    end else begin
      m_mem = r_fl ? '{default:0} : m_ex;
      m_ex  = (acc && !r_vec) ? '{1, r_ld, r_dv, r_df, r_dr} : '{default:0};
    end
  endtask

  initial begin
    bit esd, ess, ewb;
    int efw;
    n_vec = 0; n_err = 0;
    r_rst = 0; r_iv = 0; r_vec = 0; r_ld = 0; r_dv = 0; r_df = 0; r_dr = 0; r_ms = 0; r_fl = 0;
    for (int i = 0; i < NS; i++) begin r_sv[i] = 0; r_sf[i] = 0; r_sr[i] = 0; end
    drive();
    repeat (2) @(posedge clk);
    #1;

    //          rn iv vc ld dv df dr  sv sf sr ms fl | sd ss fw wb occ
    tbl.push_back(R(1,1,0,0,1,0,3,  0,0,0, 0,0, 0,0,0,0,0)); // ADD r3
    tbl.push_back(R(1,1,0,0,1,0,4,  1,0,3, 0,0, 0,0,1,0,0)); // use r3 from EX
    tbl.push_back(R(1,1,0,0,1,0,6,  1,0,3, 0,0, 0,0,2,0,0)); // use r3 from MEM
    tbl.push_back(R(1,1,0,1,1,0,5,  0,0,0, 0,0, 0,0,0,0,0)); // LOAD r5
    tbl.push_back(R(1,1,0,0,1,0,7,  1,0,5, 0,0, 1,0,0,0,0)); // load-use stall
    tbl.push_back(R(1,1,0,0,1,0,7,  1,0,5, 0,0, 0,0,2,0,0)); // then MEM fwd
    tbl.push_back(R(1,1,0,0,1,0,8,  0,0,0, 0,1, 0,0,0,0,0)); // flush kills EX r7
    tbl.push_back(R(1,1,0,0,1,0,9,  1,0,7, 0,0, 0,0,0,0,0)); // no fwd of flushed r7
    tbl.push_back(R(1,1,1,0,1,1,2,  0,0,0, 0,0, 0,0,0,0,0)); // vector write v2
    for (int k = 1; k <= VD; k++)
      tbl.push_back(R(1,1,0,0,1,0,10, 1,1,2, 0,0, 1,0,0,(k == VD),1));
    tbl.push_back(R(1,1,0,0,1,0,10, 1,1,2, 0,0, 0,0,0,0,0)); // released
    tbl.push_back(R(1,1,1,0,1,0,20, 0,0,0, 0,0, 0,0,0,0,0)); // vector write s20
    for (int k = 0; k < 6; k++)
      tbl.push_back(R(1,1,0,0,1,0,20, 0,0,0, 0,0, 1,0,0,0,1)); // WAW stall
    tbl.push_back(R(1,1,0,0,1,0,21, 0,0,0, 0,0, 0,0,0,0,1));
    tbl.push_back(R(1,0,0,0,0,0,0,  0,0,0, 0,0, 0,0,0,0,1));
    tbl.push_back(R(1,0,0,0,0,0,0,  0,0,0, 0,0, 1,1,0,1,1)); // WB conflict
    tbl.push_back(R(1,1,0,0,1,0,20, 0,0,0, 0,0, 0,0,0,0,0)); // WAW cleared
    tbl.push_back(R(1,0,0,0,0,0,0,  0,0,0, 1,0, 1,1,0,0,0)); // mem stall
    for (int k = 0; k < 3; k++)
      tbl.push_back(R(1,1,1,0,1,1,4, 0,0,0, 0,0, 0,0,0,0,k));
    tbl.push_back(R(0,0,0,0,0,0,0,  0,0,0, 0,0, 0,0,0,0,3)); // reset mid-flight
    tbl.push_back(R(1,1,0,0,1,0,1,  1,1,4, 0,0, 0,0,0,0,0));

    foreach (tbl[i]) begin
      r_rst = tbl[i].rn; r_iv = tbl[i].iv; r_vec = tbl[i].vc; r_ld = tbl[i].ld;
      r_dv = tbl[i].dv; r_df = tbl[i].df; r_dr = tbl[i].dr; r_ms = tbl[i].ms; r_fl = tbl[i].fl;
      for (int s = 0; s < NS; s++) begin r_sv[s] = 0; r_sf[s] = 0; r_sr[s] = 0; end
      r_sv[0] = tbl[i].sv; r_sf[0] = tbl[i].sf; r_sr[0] = tbl[i].sr;
      drive();
      @(negedge clk);
      chk($sformatf("row%0d stall_decode", i), int'(stall_decode), int'(tbl[i].e_sd));
      chk($sformatf("row%0d stall_scalar", i), int'(stall_scalar), int'(tbl[i].e_ss));
      chk($sformatf("row%0d fwd_sel", i), int'(fwd_sel), tbl[i].e_fw);
      chk($sformatf("row%0d wb_vector_sel", i), int'(wb_vector_sel), int'(tbl[i].e_wb));
      chk($sformatf("row%0d vec_occupancy", i), int'(vec_occupancy), tbl[i].e_occ);
      @(posedge clk);
      #1;
    end

    // random phase from a clean reset
    r_rst = 0; r_iv = 0; r_ms = 0; r_fl = 0;
    drive();
    @(posedge clk);
    #1;
    vq.delete();
    m_ex = '{default:0};
    m_mem = '{default:0};
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 99) != 0);
      r_iv  = ($urandom_range(0, 9) < 7);
      r_vec = ($urandom_range(0, 6) == 0);
      r_ld  = ($urandom_range(0, 2) == 0);
      r_dv  = ($urandom_range(0, 4) != 0);
      r_df  = 1'($urandom_range(0, 1));
      r_dr  = int'($urandom_range(0, 7));
      r_ms  = ($urandom_range(0, 9) == 0);
      r_fl  = ($urandom_range(0, 15) == 0);
      for (int s = 0; s < NS; s++) begin
        r_sv[s] = 1'($urandom_range(0, 1));
        r_sf[s] = 1'($urandom_range(0, 1));
        r_sr[s] = int'($urandom_range(0, 7));
      end
      drive();
      @(negedge clk);
      model_expect(esd, ess, ewb, efw);
      chk("rnd stall_decode", int'(stall_decode), int'(esd));
      chk("rnd stall_scalar", int'(stall_scalar), int'(ess));
      chk("rnd fwd_sel", int'(fwd_sel), efw);
      chk("rnd wb_vector_sel", int'(wb_vector_sel), int'(ewb));
      chk("rnd vec_occupancy", int'(vec_occupancy), vq.size());
      @(posedge clk);
      model_edge(esd, ess);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
